bk_accumulator: RTL and testbench

BK_ACCUMULATOR -- requirements
Module: bk_accumulator

---
 rtl/bk_pkg.sv | 14 +
 rtl/bk_add16.sv | 43 ++++
 rtl/bk_accumulator.sv | 122 ++++++++++++
 tb/tb_bk_accumulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared constants and FSM state type for the Brent-Kung accumulator.
package bk_pkg;

    localparam int OPND_W    = 16;
    localparam int ACC_W_DEF = 20;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } bk_state_e;

endpackage

// File: rtl/bk_add16.sv
// Combinational 16-bit Brent-Kung prefix adder with carry-out (carry-in = 0).
module bk_add16
    import bk_pkg::*;
(
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    output logic [OPND_W-1:0] o_sum,
    output logic              o_cout
);

    always_comb begin : prefix
        logic [OPND_W-1:0] w_h;
        logic [OPND_W-1:0] w_g;
        logic [OPND_W-1:0] w_p;
        w_h = i_a ^ i_b;
        w_g = i_a & i_b;
        w_p = w_h;
        // Up-sweep builds group (g,p) at power-of-two boundaries.
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < OPND_W; i++) begin
                if (i >= (1 << d) && ((i + 1) % (2 << d)) == 0) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << d)]);
                    w_p[i] = w_p[i] & w_p[i - (1 << d)];
                end
            end
        end
        // Down-sweep fills in the remaining prefix carries.
        for (int d = 2; d >= 0; d--) begin
            for (int i = 0; i < OPND_W; i++) begin
                if (i > (1 << d) && ((i + 1) % (2 << d)) == (1 << d)) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << d)]);
                    w_p[i] = w_p[i] & w_p[i - (1 << d)];
                end
            end
        end
        o_sum[0] = w_h[0];
        for (int i = 1; i < OPND_W; i++) begin
            o_sum[i] = w_h[i] ^ w_g[i - 1];
        end
        o_cout = w_g[OPND_W - 1];
    end

endmodule

// File: rtl/bk_accumulator.sv
// Grouped pair-sum accumulator with valid/ready handshakes.
// Define BK_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module bk_accumulator
    import bk_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_data1,
    input  logic [OPND_W-1:0] in_data2,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bk_state_e r_state;
    bk_state_e w_state_nxt;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [OPND_W-1:0] w_psum;
    logic              w_pcarry;
    logic [ACC_W-1:0]  w_pair;
    logic [ACC_W:0]    w_add;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_accept;

    bk_add16 u_add (
        .i_a    (in_data1),
        .i_b    (in_data2),
        .o_sum  (w_psum),
        .o_cout (w_pcarry)
    );

    assign w_pair   = ACC_W'({w_pcarry, w_psum});
    assign w_add    = {1'b0, r_acc} + {1'b0, w_pair};
    assign w_accept = in_valid && in_ready;

`ifdef BK_ACC_SAT_EN
    assign w_acc_nxt = (r_ovf || w_add[ACC_W]) ? '1 : w_add[ACC_W-1:0];
`else
    assign w_acc_nxt = w_add[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == ST_HOLD) begin
            if (out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_acc <= w_pair;
                r_cnt <= CNT_W'(1);
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_nxt;
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_add[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_bk_accumulator.sv
// Scoreboard bench for bk_accumulator (default widths plus an ACC_W=17 copy).
module tb_bk_accumulator;

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data1;
    logic [15:0] in_data2;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_data1;
    logic [15:0] s_in_data2;
    logic        s_in_last;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [16:0] s_out_sum;
    logic [7:0]  s_out_count;
    logic        s_out_ovf;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    int n_chk;
    int n_err;

    longint unsigned m_acc[2];
    int              m_cnt[2];
    logic            m_ovf[2];
    logic            m_first[2];

    bk_accumulator u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    bk_accumulator #(.ACC_W(17), .CNT_W(8)) u_d17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data1  (s_in_data1),
        .in_data2  (s_in_data2),
        .in_last   (s_in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_count (s_out_count),
        .out_ovf   (s_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) check("excl0", {63'd0, in_ready}, 64'd0);
        if (out_valid && out_ready) begin
            if (q0.size() == 0) begin
                check("spurious0", 64'd1, {63'd0, out_ready & 1'b0});
            end else begin
                e0 = q0.pop_front();
                check("sum0", 64'(out_sum), 64'(e0.sum));
                check("cnt0", 64'(out_count), 64'(e0.cnt));
                check("ovf0", 64'(out_ovf), 64'(e0.ovf));
            end
        end
        if (s_out_valid && s_out_ready) begin
            if (q1.size() == 0) begin
                check("spurious1", 64'd1, {63'd0, s_out_ready & 1'b0});
            end else begin
                e1 = q1.pop_front();
                check("sum1", 64'(s_out_sum), 64'(e1.sum));
                check("cnt1", 64'(s_out_count), 64'(e1.cnt));
                check("ovf1", 64'(s_out_ovf), 64'(e1.ovf));
            end
        end
    end

    task automatic model(input int w, input logic [15:0] a,
                         input logic [15:0] b, input logic last);
        longint unsigned pair;
        longint unsigned s;
        longint unsigned mask;
        int aw;
        exp_t e;
        aw   = (w == 0) ? 20 : 17;
        mask = (64'd1 << aw) - 1;
        pair = 64'(a) + 64'(b);
        if (m_first[w]) begin
            m_acc[w] = pair;
            m_cnt[w] = 1;
            m_ovf[w] = 1'b0;
        end else begin
            s = m_acc[w] + pair;
            if (s > mask) m_ovf[w] = 1'b1;
`ifdef BK_ACC_SAT_EN
            m_acc[w] = m_ovf[w] ? mask : s;
`else
            m_acc[w] = s & mask;
`endif
            if (m_cnt[w] < 255) m_cnt[w]++;
        end
        m_first[w] = 1'b0;
        if (last) begin
            e.sum = 32'(m_acc[w]);
            e.cnt = 8'(m_cnt[w]);
            e.ovf = m_ovf[w];
            if (w == 0) q0.push_back(e);
            else q1.push_back(e);
            m_first[w] = 1'b1;
        end
    endtask

    task automatic beat(input int w, input logic [15:0] a,
                        input logic [15:0] b, input logic last);
        int t;
        t = 0;
        if (w == 0) begin
            in_valid = 1'b1;
            in_data1 = a;
            in_data2 = b;
            in_last  = last;
            while (!in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end else begin
            s_in_valid = 1'b1;
            s_in_data1 = a;
            s_in_data2 = b;
            s_in_last  = last;
            while (!s_in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("ready_wait", 64'(t < 100), 64'd1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        model(w, a, b, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int t;
        int len;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 2; i++) begin
            m_first[i] = 1'b1;
            m_acc[i]   = 0;
            m_cnt[i]   = 0;
            m_ovf[i]   = 1'b0;
        end
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data1    = '0;
        in_data2    = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data1  = '0;
        s_in_data2  = '0;
        s_in_last   = 1'b0;
        s_out_ready = 1'b1;
        idle(3);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_iready", 64'(in_ready), 64'd1);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_cnt", 64'(out_count), 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);
        check("rst_iready17", 64'(s_in_ready), 64'd1);
        rst_n = 1'b1;
        idle(1);

        beat(0, 16'h0003, 16'h0004, 1'b1);
        check("latency", 64'(out_valid), 64'd1);
        idle(2);

        beat(0, 16'hFFFF, 16'h0001, 1'b0);
        beat(0, 16'h8000, 16'h8000, 1'b0);
        beat(0, 16'h0001, 16'h0000, 1'b1);
        idle(2);

        beat(1, 16'hFFFF, 16'hFFFF, 1'b0);
        beat(1, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(2);

        out_ready = 1'b0;
        beat(0, 16'h0010, 16'h0020, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_ovalid", 64'(out_valid), 64'd1);
            check("hold_iready", 64'(in_ready), 64'd0);
            check("hold_sum", 64'(out_sum), 64'h30);
            check("hold_cnt", 64'(out_count), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_iready", 64'(in_ready), 64'd1);
        check("rel_ovalid", 64'(out_valid), 64'd0);
        idle(1);

        beat(0, 16'h0101, 16'h0202, 1'b0);
        beat(0, 16'h0303, 16'h0404, 1'b0);
        rst_n      = 1'b0;
        m_first[0] = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ovalid", 64'(out_valid), 64'd0);
        check("mid_rst_iready", 64'(in_ready), 64'd1);
        check("mid_rst_sum", 64'(out_sum), 64'd0);
        rst_n = 1'b1;
        idle(1);
        beat(0, 16'h0005, 16'h0005, 1'b1);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            beat(0, 16'h0000, 16'h0001, 1'(i == 299));
        end
        idle(2);

        for (int g = 0; g < 6; g++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                beat(0, 16'($urandom), 16'($urandom), 1'(i == len - 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            idle($urandom_range(0, 3));
            out_ready = 1'b1;
        end

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 64'(q0.size() + q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
